uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//   Frame controller for the UART transmit path. Accepts a parallel byte, sequences the
//   bit serializer (ser_en / ser_done handshake), computes optional parity, and muxes
//   start / data / parity / stop bits onto the line, one bit per clk.
//   Sits between the host write interface and the serializer + line output.
// PARAMETERS
//   DATA_WIDTH  8               data bits per frame; must match the serializer width
//   TIMEOUT     DATA_WIDTH+2    max cycles in DATA waiting for ser_done before abort
// PORTS
//   clk          in   1           system clock, one line bit per rising edge
//   rst          in   1           asynchronous, active-high reset
//   p_data       in   DATA_WIDTH  byte to transmit
//   data_valid   in   1           request; accepted in IDLE or STOP (see below)
//   par_en       in   1           1 = insert parity bit; sampled on accept
//   par_typ      in   1           0 = even, 1 = odd; sampled on accept
//   ser_done     in   1           serializer has shifted DATA_WIDTH bits
//   ser_data     in   1           current serial bit from the serializer
//   ser_en       out  1           serializer shift enable; low = serializer loads ser_p_data
//   ser_p_data   out  DATA_WIDTH  parallel word presented to the serializer
//   tx_out       out  1           UART line, idle high
//   busy         out  1           frame in progress
//   frame_err    out  1           one-cycle pulse: DATA timeout abort
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, data_reg=0, par_bit=0, par_en_r=0,
//     tmo_cnt=0, ser_en=0, tx_out=1, busy=0, frame_err=0. Reset mid-frame drops the
//     frame; line returns high immediately; no err pulse.
//   - States: IDLE, START, DATA, PARITY, STOP (registered, one bit per cycle).
//   - Accept: data_valid=1 while state is IDLE or STOP -> next state START; latch
//     data_reg=p_data, par_en_r=par_en, par_bit=^p_data ^ par_typ.
//     data_valid in START/DATA/PARITY is ignored (no queueing).
//   - ser_p_data = p_data in IDLE/STOP (serializer loads on the accept edge), else data_reg.
//   - ser_en = 1 in START and DATA, else 0. Serializer output lags ser_en by one edge,
//     so bit0 appears on ser_data in the first DATA cycle.
//   - Transitions:
//       START  -> DATA (always, 1 cycle)
//       DATA   -> PARITY if ser_done && par_en_r; STOP if ser_done && !par_en_r;
//                 IDLE with frame_err=1 if tmo_cnt reaches TIMEOUT-1 without ser_done
//       PARITY -> STOP (1 cycle)
//       STOP   -> START if data_valid (back-to-back, no idle bit); else IDLE
//   - tx_out (combinational from state): IDLE 1, START 0, DATA ser_data,
//     PARITY par_bit, STOP 1.
//   - busy = (state != IDLE). busy stays 1 across back-to-back frames.
//   - tmo_cnt: cleared outside DATA, increments each DATA cycle; width clog2(TIMEOUT+1).
//   - ser_done takes priority over timeout on the same cycle.
//   - Frame length: 10 cycles (no parity) / 11 (parity), START through STOP inclusive.
// TESTING
//   1. p_data=8'hA5, par_en=0, one-cycle data_valid -> tx_out: 0,1,0,1,0,0,1,0,1,1;
//      busy high exactly 10 cycles; frame_err never set.
//   2. p_data=8'hA5, par_en=1, par_typ=0 -> parity bit 0, 11-cycle frame;
//      repeat with par_typ=1 -> parity bit 1.
//   3. 8'h00 then 8'hFF, data_valid held high through STOP -> second START directly
//      follows first STOP; busy never drops; line 0,0x8,1,0,1x8,1.
//   4. ser_done forced 0 -> after TIMEOUT (10) DATA cycles frame_err pulses 1 cycle,
//      state IDLE, tx_out=1, ser_en=0; next frame transmits correctly.
//   5. rst asserted on 4th DATA cycle -> same cycle tx_out=1, busy=0, ser_en=0;
//      after release, new 8'h3C frame is bit-exact.
//   6. data_valid pulsed during DATA and PARITY -> ignored; frame unchanged; no extra frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// UART transmit controller bus: host request, serializer handshake and line output.
// The master drives the request and serializer feedback; the slave is the controller.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_done;
  logic                  ser_data;
  logic                  ser_en;
  logic [DATA_WIDTH-1:0] ser_p_data;
  logic                  tx_out;
  logic                  busy;
  logic                  frame_err;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    output ser_done, ser_data,
    input  ser_en, ser_p_data, tx_out, busy, frame_err
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    input  ser_done, ser_data,
    output ser_en, ser_p_data, tx_out, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop bits
// and drives the serializer enable, with a DATA-phase timeout abort.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = DATA_WIDTH + 2
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_bit;
  logic                  par_en_r;
  logic [TW-1:0]         tmo_cnt;
  logic                  frame_err_r;
  logic                  accept;
  logic                  tmo_hit;

  assign accept  = bus.data_valid &&
                   (state == IDLE || state == STOP);
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = DATA;
      // ser_done wins over a timeout landing on the same cycle
      DATA: begin
        if (bus.ser_done)
          state_nxt = par_en_r ? PARITY : STOP;
        else if (tmo_hit)
          state_nxt = IDLE;
      end
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_reg    <= '0;
      par_bit     <= 1'b0;
      par_en_r    <= 1'b0;
      tmo_cnt     <= '0;
      frame_err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        data_reg <= bus.p_data;
        par_en_r <= bus.par_en;
        par_bit  <= ^bus.p_data ^ bus.par_typ;
      end
      if (state == DATA)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      frame_err_r <= (state == DATA) &&
                     !bus.ser_done && tmo_hit;
    end
  end

  always_comb begin
    bus.tx_out = 1'b1;
    unique case (state)
      IDLE:    bus.tx_out = 1'b1;
      START:   bus.tx_out = 1'b0;
      DATA:    bus.tx_out = bus.ser_data;
      PARITY:  bus.tx_out = par_bit;
      STOP:    bus.tx_out = 1'b1;
      default: bus.tx_out = 1'b1;
    endcase
  end

  // Serializer loads while ser_en is low, so it sees p_data on the accept edge
  assign bus.ser_p_data = (state == IDLE || state == STOP) ?
                          bus.p_data : data_reg;
  assign bus.ser_en     = (state == START) || (state == DATA);
  assign bus.busy       = (state != IDLE);
  assign bus.frame_err  = frame_err_r;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl: a shift-register serializer model
// drives ser_data/ser_done; expected line bits come from the frame format.
module tb_uart_tx_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   no_done = 1'b0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sh;
  logic [3:0] scnt;
  logic       sbit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh   <= '0;
      scnt <= '0;
      sbit <= 1'b0;
    end else if (!bus.ser_en) begin
      sh   <= bus.ser_p_data;
      scnt <= '0;
    end else begin
      sbit <= sh[0];
      sh   <= sh >> 1;
      if (scnt != 4'd15) scnt <= scnt + 4'd1;
    end
  end

  assign bus.ser_done = (scnt == 4'd8) && !no_done;
  assign bus.ser_data = sbit;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic line_bit(logic [7:0] d, bit pe, bit pt,
                                    int i, int n);
    if (i == 0)          return 1'b0;
    if (i <= 8)          return d[i-1];
    if (pe && i == n-2)  return ^{d, pt};
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(int nfr, logic [7:0] d0, logic [7:0] d1,
                      bit pe, bit pt, bit noise);
    logic [7:0] d;
    int n;
    n = pe ? 11 : 10;
    bus.data_valid = 1'b1;
    bus.p_data     = d0;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    step();
    for (int f = 0; f < nfr; f++) begin
      d = (f == 0) ? d0 : d1;
      for (int i = 0; i < n; i++) begin
        chk($sformatf("tx[%0d]", i), 32'(bus.tx_out),
            32'(line_bit(d, pe, pt, i, n)));
        chk("busy", 32'(bus.busy), 32'd1);
        chk("ser_en", 32'(bus.ser_en), 32'(i <= 8));
        chk("ferr", 32'(bus.frame_err), 32'd0);
        bus.data_valid = 1'b0;
        if (noise && i >= 1 && i <= n-2) begin
          bus.data_valid = 1'($urandom);
          bus.p_data     = 8'($urandom);
          bus.par_en     = 1'($urandom);
          bus.par_typ    = 1'($urandom);
        end
        if (i == n-1 && f+1 < nfr) begin
          bus.data_valid = 1'b1;
          bus.p_data     = d1;
          bus.par_en     = pe;
          bus.par_typ    = pt;
        end
        step();
      end
    end
    bus.data_valid = 1'b0;
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_tx", 32'(bus.tx_out), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    step();
    step();
    chk("rst_tx", 32'(bus.tx_out), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ser_en", 32'(bus.ser_en), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    rst = 1'b0;
    step();
    bus.p_data = 8'h5A;
    #1;
    chk("idle_ser_p", 32'(bus.ser_p_data), 32'h5A);

    xfer(1, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
    xfer(1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
    xfer(1, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0);
    xfer(2, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    xfer(1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b1);

    no_done        = 1'b1;
    bus.data_valid = 1'b1;
    bus.p_data     = 8'h81;
    bus.par_en     = 1'b0;
    step();
    bus.data_valid = 1'b0;
    chk("tmo_start", 32'(bus.tx_out), 32'd0);
    step();
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("tmo_busy[%0d]", k), 32'(bus.busy), 32'd1);
      chk("tmo_ser_en", 32'(bus.ser_en), 32'd1);
      chk("tmo_ferr_lo", 32'(bus.frame_err), 32'd0);
      step();
    end
    chk("tmo_ferr", 32'(bus.frame_err), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_tx", 32'(bus.tx_out), 32'd1);
    chk("tmo_ser_en_lo", 32'(bus.ser_en), 32'd0);
    step();
    chk("tmo_ferr_pulse", 32'(bus.frame_err), 32'd0);
    no_done = 1'b0;
    xfer(1, 8'h96, 8'h00, 1'b1, 1'b1, 1'b0);

    bus.data_valid = 1'b1;
    bus.p_data     = 8'hE7;
    bus.par_en     = 1'b1;
    step();
    bus.data_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_tx", 32'(bus.tx_out), 32'(1'b0));
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_tx", 32'(bus.tx_out), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ser_en", 32'(bus.ser_en), 32'd0);
    chk("arst_ferr", 32'(bus.frame_err), 32'd0);
    step();
    rst = 1'b0;
    step();
    xfer(1, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);

    repeat (25) begin
      xfer($urandom_range(1, 2), 8'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
